// File: rtl/sc_pkg.sv
// Shared definitions for the sc_computer front end: next-PC select codes,
// fetch FSM states and the opcode map that the control unit also decodes.
package sc_pkg;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_BR  = 2'b01;
  localparam logic [1:0] PC_JR  = 2'b10;
  localparam logic [1:0] PC_J   = 2'b11;

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } fetch_state_e;

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_J     = 6'h02,
    OP_JAL   = 6'h03,
    OP_BEQ   = 6'h04,
    OP_BNE   = 6'h05,
    OP_ADDI  = 6'h08,
    OP_ANDI  = 6'h0C,
    OP_ORI   = 6'h0D,
    OP_LUI   = 6'h0F,
    OP_LW    = 6'h23,
    OP_SW    = 6'h2B
  } opcode_e;

endpackage

// File: rtl/sc_fetch_if.sv
// Instruction-memory fetch port of the sc_computer front end.
interface sc_fetch_if;
  // imem_req/imem_addr are raised by the master and held stable until the
  // slave answers with a one-cycle imem_ack carrying imem_rdata; the slave may
  // insert any number of wait states before acking.
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/sc_npc.sv
// Combinational next-PC mux: sequential, branch, register-indirect and
// absolute jump targets, plus a flag for misaligned jr targets.
module sc_npc
  import sc_pkg::*;
(
  input  logic [31:0] pc4,
  input  logic [25:0] inst,
  input  logic [31:0] ra,
  input  logic [1:0]  pcsource,
  output logic [31:0] npc,
  output logic        misalign
);

  logic [31:0] br_off;

  assign br_off = {{14{inst[15]}}, inst[15:0], 2'b00};

  always_comb begin
    npc = pc4;
    case (pcsource)
      PC_BR:   npc = pc4 + br_off;
      PC_JR:   npc = {ra[31:2], 2'b00};
      PC_J:    npc = {pc4[31:28], inst[25:0], 2'b00};
      default: npc = pc4;
    endcase
  end

  assign misalign = (pcsource == PC_JR) && (ra[1:0] != 2'b00);

endmodule

// File: rtl/sc_fetch.sv
// Instruction-fetch stage: owns the PC, fetches over the imem handshake and
// holds the instruction until the datapath commits it.
module sc_fetch
  import sc_pkg::*;
#(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        pcsource,
  input  logic [31:0]       ra,
  input  logic              commit,
  sc_fetch_if.master        imem,
  output logic [31:0]       inst,
  output logic              inst_valid,
  output logic [31:0]       pc,
  output logic [31:0]       pc4,
  output logic [CNT_W-1:0]  retired,
  output logic              addr_err,
  output fetch_state_e      dbg_state
);

  fetch_state_e     state_q;
  logic [31:0]      pc_q;
  logic [31:0]      inst_q;
  logic             valid_q;
  logic             req_q;
  logic [CNT_W-1:0] retired_q;
  logic             err_q;
  logic [31:0]      npc_d;
  logic             misalign;

  assign pc4 = pc_q + 32'd4;

  sc_npc u_npc (
    .pc4      (pc4),
    .inst     (inst_q[25:0]),
    .ra       (ra),
    .pcsource (pcsource),
    .npc      (npc_d),
    .misalign (misalign)
  );

  // req is registered so it is low throughout reset; an ack arriving in the
  // first FETCH cycle after reset is still taken as the PC_RESET fetch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= FETCH;
      pc_q      <= {PC_RESET[31:2], 2'b00};
      inst_q    <= '0;
      valid_q   <= 1'b0;
      req_q     <= 1'b0;
      retired_q <= '0;
      err_q     <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem.imem_ack) begin
            inst_q  <= imem.imem_rdata;
            valid_q <= 1'b1;
            req_q   <= 1'b0;
            state_q <= HOLD;
          end else begin
            req_q <= 1'b1;
          end
        end
        HOLD: begin
          if (commit) begin
            pc_q      <= npc_d;
            valid_q   <= 1'b0;
            retired_q <= retired_q + CNT_W'(1);
            req_q     <= 1'b1;
            state_q   <= FETCH;
            if (misalign) err_q <= 1'b1;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = pc_q;
  assign inst           = inst_q;
  assign inst_valid     = valid_q;
  assign pc             = pc_q;
  assign retired        = retired_q;
  assign addr_err       = err_q;
  assign dbg_state      = state_q;

endmodule
